// File: rtl/avm_cmd_master.sv
// Avalon-MM master: one valid/ready command becomes a single read or write transfer and returns one response.
// Write resp 2 edges after accept, read 2+READ_LATENCY; waitrequest stalls the strobe, rsp_ready low holds the response.
module avm_cmd_master #(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  input  logic [BE_W-1:0]   cmd_byteenable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_write,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, LAT, RESP} state_t;

  state_t              state_q;
  logic                wr_q;
  logic [WC_W-1:0]     wait_cnt_q;
  logic [3:0]          lat_cnt_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_error_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic [DATA_W-1:0]   avm_writedata_q;
  logic [BE_W-1:0]     avm_byteenable_q;
  logic                avm_write_q;
  logic                avm_read_q;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q          <= IDLE;
      wr_q             <= 1'b0;
      wait_cnt_q       <= '0;
      lat_cnt_q        <= '0;
      cmd_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_error_q      <= 1'b0;
      busy_q           <= 1'b0;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            wr_q             <= cmd_write;
            avm_address_q    <= cmd_address;
            avm_writedata_q  <= cmd_writedata;
            avm_byteenable_q <= cmd_byteenable;
            avm_write_q      <= cmd_write;
            avm_read_q       <= !cmd_write;
            cmd_ready_q      <= 1'b0;
            busy_q           <= 1'b1;
            state_q          <= BUS;
          end else begin
            // Also raises cmd_ready on the first edge after reset release.
            cmd_ready_q <= 1'b1;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_write_q <= 1'b0;
            avm_read_q  <= 1'b0;
            wait_cnt_q  <= '0;
            rsp_error_q <= 1'b0;
            if (wr_q) begin
              rsp_data_q <= '0;
              state_q    <= RESP;
            end else if (READ_LATENCY == 0) begin
              rsp_data_q <= avm_readdata;
              state_q    <= RESP;
            end else begin
              lat_cnt_q <= 4'(READ_LATENCY - 1);
              state_q   <= LAT;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt_q == WC_W'(TIMEOUT - 1))) begin
            // This edge is the TIMEOUT-th stalled one: give up on the slave.
            avm_write_q <= 1'b0;
            avm_read_q  <= 1'b0;
            wait_cnt_q  <= '0;
            rsp_error_q <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        LAT: begin
          if (lat_cnt_q == 4'd0) begin
            rsp_data_q  <= avm_readdata;
            rsp_error_q <= 1'b0;
            state_q     <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_error      = rsp_error_q;
  assign busy           = busy_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_write      = avm_write_q;
  assign avm_read       = avm_read_q;

endmodule

// File: tb/tb_avm_cmd_master.sv
// Directed bench for avm_cmd_master: transaction table plus backpressure, back-to-back and mid-read reset sequences.
module tb_avm_cmd_master;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic [3:0]  cmd_byteenable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic [2:0]  avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  avm_cmd_master #(
    .ADDR_W(3), .DATA_W(32), .BE_W(4), .READ_LATENCY(1), .TIMEOUT(TO)
  ) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_writedata  (cmd_writedata),
    .cmd_byteenable (cmd_byteenable),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_error      (rsp_error),
    .busy           (busy),
    .avm_address    (avm_address),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_write      (avm_write),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stall = number of waitrequest-high edges in BUS; exp_lat = edges from accept to first rsp_valid.
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tv [8];
  vec_t bp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v, input bit hold);
    int   e;
    int   acc_e;
    int   rsp_e;
    logic s_exp;
    @(negedge clk);
    cmd_valid       = 1'b1;
    cmd_write       = v.wr;
    cmd_address     = v.addr;
    cmd_writedata   = v.wdata;
    cmd_byteenable  = v.be;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    // Scramble the command fields: they must not be resampled outside IDLE.
    cmd_valid      = 1'b0;
    cmd_write      = ~v.wr;
    cmd_address    = ~v.addr;
    cmd_writedata  = ~v.wdata;
    cmd_byteenable = ~v.be;
    chk("accept_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_strobe", 32'({avm_write, avm_read}), v.wr ? 32'd2 : 32'd1);
    e = 0; acc_e = -1; rsp_e = -1;
    while (rsp_e < 0 && e < 40) begin
      avm_waitrequest = (e < v.stall);
      avm_readdata    = (acc_e >= 0 && e == acc_e) ? v.rdata : 32'hDEADBEEF;
      @(posedge clk);
      e++;
      if (acc_e < 0 && !avm_waitrequest) acc_e = e;
      @(negedge clk);
      s_exp = (acc_e < 0) && (e < TO);
      chk("strobe", 32'(avm_write | avm_read), 32'(s_exp));
      chk("rd_wr_excl", 32'(avm_write & avm_read), 32'd0);
      if (s_exp) begin
        chk("hold_addr", 32'(avm_address), 32'(v.addr));
        chk("hold_wdata", avm_writedata, v.wdata);
        chk("hold_be", 32'(avm_byteenable), 32'(v.be));
      end
      if (rsp_valid) rsp_e = e;
    end
    chk("rsp_latency", rsp_e, v.exp_lat);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_error", 32'(rsp_error), 32'(v.exp_err));
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic s;
    tv[0] = '{1'b1, 3'd4, 32'h0000FFFF, 4'hF, 0,  32'h0,        2,  32'h0,        1'b0};
    tv[1] = '{1'b0, 3'd2, 32'h0,        4'hF, 0,  32'h0000A5A5, 3,  32'h0000A5A5, 1'b0};
    tv[2] = '{1'b1, 3'd2, 32'h12345678, 4'h3, 3,  32'h0,        5,  32'h0,        1'b0};
    tv[3] = '{1'b0, 3'd7, 32'h0,        4'h5, 2,  32'hCAFEF00D, 5,  32'hCAFEF00D, 1'b0};
    tv[4] = '{1'b1, 3'd1, 32'h55AA55AA, 4'hC, 99, 32'h0,        9,  32'h0,        1'b1};
    tv[5] = '{1'b0, 3'd6, 32'h0,        4'hF, 99, 32'h11112222, 9,  32'h0,        1'b1};
    tv[6] = '{1'b0, 3'd0, 32'h0,        4'hF, 7,  32'h87654321, 10, 32'h87654321, 1'b0};
    tv[7] = '{1'b1, 3'd3, 32'hA0A0A0A0, 4'hF, 8,  32'h0,        9,  32'h0,        1'b1};
    bp    = '{1'b0, 3'd3, 32'h0,        4'hF, 0,  32'h0BADF00D, 3,  32'h0BADF00D, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_writedata = '0; cmd_byteenable = '0; rsp_ready = 1'b1;
    avm_readdata = '0; avm_waitrequest = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({avm_write, avm_read}), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1 chk("release_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("release_cmd_ready_high", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run(tv[i], 1'b0);

    // Backpressure: response held, a pending command must not be taken.
    rsp_ready = 1'b0;
    run(bp, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd3;
    cmd_writedata = 32'h00000033; cmd_byteenable = 4'hF;
    avm_waitrequest = 1'b0; avm_readdata = 32'h5A5A0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h0BADF00D);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_strobe", 32'(avm_write | avm_read), 32'd0);
    end

    // Back-to-back with cmd_valid held: strobes at edges 1 and 5, responses at 3 and 8.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      s = avm_write | avm_read;
      chk("b2b_strobe", 32'(s), 32'(i == 1 || i == 5));
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'(i == 3 || i == 8));
      if (i == 1) begin
        chk("b2b_first_write", 32'({avm_write, avm_address}), 32'({1'b1, 3'd3}));
        cmd_write = 1'b0; cmd_address = 3'd5;
      end
      if (i == 5) begin
        chk("b2b_second_read", 32'({avm_read, avm_address}), 32'({1'b1, 3'd5}));
        cmd_valid = 1'b0;
      end
      if (i == 8) chk("b2b_read_data", rsp_data, 32'h5A5A0000);
    end

    // Reset while waiting in LAT.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd2;
    avm_waitrequest = 1'b0; avm_readdata = 32'h77777777;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mrst_read_strobe", 32'(avm_read), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_lat_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_addr", 32'(avm_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk("mrst_cmd_ready_rise", 32'(cmd_ready), 32'd1);
      chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
